// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter.
// Region decode, DMA state encoding and echo-page folding.
package oam_dma_arbiter_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  typedef enum logic [1:0] {
    RGN_MAIN,
    RGN_HRAM,
    RGN_DREG
  } bus_region_t;

  localparam addr_t HRAM_LO  = 16'hFF80;
  localparam addr_t HRAM_HI  = 16'hFFFE;
  localparam addr_t DMA_REG  = 16'hFF46;
  localparam addr_t OAM_BASE = 16'hFE00;

  // E0-FF source pages alias the C0-DF work RAM
  function automatic logic [7:0] echo_page(
    input logic [7:0] src
  );
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU, main-bus and HRAM signal bundle around the arbiter.
// master = arbiter side, slave = core/bus/HRAM side.
interface oam_dma_arbiter_if;
  import oam_dma_arbiter_pkg::*;

  addr_t       cpu_r_addr;
  logic [7:0]  cpu_r_data;
  addr_t       cpu_w_addr;
  logic [7:0]  cpu_w_data;
  logic        cpu_w_wen;

  addr_t       mem_r_addr;
  logic [7:0]  mem_r_data;
  addr_t       mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_w_wen;

  logic [6:0]  hram_r_addr;
  logic [7:0]  hram_r_data;
  logic [6:0]  hram_w_addr;
  logic [7:0]  hram_w_data;
  logic        hram_w_wen;

  logic        dma_active;

  modport master (
    input  cpu_r_addr,
    input  cpu_w_addr,
    input  cpu_w_data,
    input  cpu_w_wen,
    output cpu_r_data,
    output mem_r_addr,
    input  mem_r_data,
    output mem_w_addr,
    output mem_w_data,
    output mem_w_wen,
    output hram_r_addr,
    input  hram_r_data,
    output hram_w_addr,
    output hram_w_data,
    output hram_w_wen,
    output dma_active
  );

  modport slave (
    output cpu_r_addr,
    output cpu_w_addr,
    output cpu_w_data,
    output cpu_w_wen,
    input  cpu_r_data,
    input  mem_r_addr,
    output mem_r_data,
    input  mem_w_addr,
    input  mem_w_data,
    input  mem_w_wen,
    input  hram_r_addr,
    output hram_r_data,
    input  hram_w_addr,
    input  hram_w_data,
    input  hram_w_wen,
    input  dma_active
  );

endinterface

// File: rtl/bus_region_decode.sv
// Classifies a core address as HRAM, DMA register or main bus.
// FFFF (IE) deliberately falls outside HRAM.
module bus_region_decode
  import oam_dma_arbiter_pkg::*;
#(
  parameter addr_t DREG_ADDR = DMA_REG
) (
  input  addr_t       addr,
  output bus_region_t rgn
);

  always_comb begin
    rgn = RGN_MAIN;
    unique case (1'b1)
      (addr >= HRAM_LO && addr <= HRAM_HI): rgn = RGN_HRAM;
      (addr == DREG_ADDR):                  rgn = RGN_DREG;
      default:                              rgn = RGN_MAIN;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Main-bus arbiter between the core and the OAM DMA engine.
// HRAM stays on a private port so the core can run from it during DMA.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int    XFER_LEN     = 160,
  parameter addr_t DMA_REG_ADDR = 16'hFF46,
  parameter addr_t OAM_BASE     = 16'hFE00
) (
  input  logic               clk,
  input  logic               rst_n,
  oam_dma_arbiter_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'(DMA_IDLE);
  localparam logic [1:0] S_START = 2'(DMA_START);
  localparam logic [1:0] S_RD    = 2'(DMA_RD);
  localparam logic [1:0] S_WR    = 2'(DMA_WR);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  logic [1:0]  state;
  logic [7:0]  src_reg;
  logic [7:0]  idx;
  logic [7:0]  byte_buf;
  logic [7:0]  eff_src;
  logic        busy;
  logic        dreg_wr;
  bus_region_t r_rgn;
  bus_region_t w_rgn;

  bus_region_decode #(
    .DREG_ADDR (DMA_REG_ADDR)
  ) u_rd_dec (
    .addr (bus.cpu_r_addr),
    .rgn  (r_rgn)
  );

  bus_region_decode #(
    .DREG_ADDR (DMA_REG_ADDR)
  ) u_wr_dec (
    .addr (bus.cpu_w_addr),
    .rgn  (w_rgn)
  );

  assign dreg_wr = bus.cpu_w_wen && (w_rgn == RGN_DREG);
  assign busy    = (state == S_RD) || (state == S_WR);
  assign eff_src = echo_page(src_reg);

  // a register write restarts the copy from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      src_reg  <= 8'h00;
      idx      <= 8'h00;
      byte_buf <= 8'h00;
    end else if (dreg_wr) begin
      src_reg  <= bus.cpu_w_data;
      idx      <= 8'h00;
      state    <= S_START;
    end else begin
      unique case (state)
        S_START: state <= S_RD;
        S_RD: begin
          byte_buf <= bus.mem_r_data;
          state    <= S_WR;
        end
        S_WR: begin
          if (idx == LAST_IDX) begin
            state <= S_IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dma_active  = busy;

    bus.hram_r_addr = bus.cpu_r_addr[6:0];
    bus.hram_w_addr = bus.cpu_w_addr[6:0];
    bus.hram_w_data = bus.cpu_w_data;
    bus.hram_w_wen  = bus.cpu_w_wen && (w_rgn == RGN_HRAM);

    bus.mem_r_addr  = bus.cpu_r_addr;
    bus.mem_w_addr  = bus.cpu_w_addr;
    bus.mem_w_data  = bus.cpu_w_data;
    bus.mem_w_wen   = bus.cpu_w_wen && (w_rgn == RGN_MAIN) && !busy;

    if (state == S_RD) begin
      bus.mem_r_addr = {eff_src, idx};
      bus.mem_w_wen  = 1'b0;
    end
    if (state == S_WR) begin
      bus.mem_w_addr = OAM_BASE + {8'h00, idx};
      bus.mem_w_data = byte_buf;
      bus.mem_w_wen  = 1'b1;
    end

    unique case (r_rgn)
      RGN_HRAM: bus.cpu_r_data = bus.hram_r_data;
      RGN_DREG: bus.cpu_r_data = src_reg;
      default:  bus.cpu_r_data = busy ? 8'hFF : bus.mem_r_data;
    endcase
  end

endmodule
